axi4_lite_sram: RTL and testbench

AXI4_LITE_SRAM -- requirements
Module: axi4_lite_sram

---
 rtl/axi4_lite_sram_pkg.sv | 26 ++
 rtl/axi4_lite_sram_delay.sv | 59 +++++
 rtl/axi4_lite_sram.sv | 244 ++++++++++++++++++++++++
 tb/tb_axi4_lite_sram.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_sram_pkg.sv
// axi4_lite_sram_pkg
// Shared widths, response codes and latency-counter helpers for the AXI4-Lite SRAM.
// Optional feature macro: AXI4_LITE_SRAM_RAND_DELAY_EN (adds the LFSR delay helpers).
package axi4_lite_sram_pkg;

   localparam int unsigned ADDR_WIDTH = 32;
   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned MASK_WIDTH = 4;
   localparam int unsigned RESP_WIDTH = 2;

   localparam logic [RESP_WIDTH-1:0] RESP_OKEY   = 2'b00;
   localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = 2'b10;

   // Wide enough for 15 programmed cycles plus a 4-bit random extension.
   localparam int unsigned CNT_WIDTH = 5;

`ifdef AXI4_LITE_SRAM_RAND_DELAY_EN
   localparam logic [3:0] LFSR_SEED = 4'b1001;

   // Fibonacci LFSR for x^4 + x^3 + 1.
   function automatic logic [3:0] lfsr4_next(input logic [3:0] v);
      return {v[2:0], v[3] ^ v[2]};
   endfunction
`endif

endpackage

// File: rtl/axi4_lite_sram_delay.sv
// axi4_lite_sram_delay
// Latency counter for one channel: loads a target on start, counts while tick is high and
// flags done in the last waiting cycle. With AXI4_LITE_SRAM_RAND_DELAY_EN defined the target
// is LATENCY plus a per-channel 4-bit LFSR value that advances on every start.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   start    : transaction accepted, load a new target
//   tick     : channel is in its wait state
//   zero     : the target that start would load is zero (wait state is skipped)
//   done     : final wait cycle, leave the wait state at the next edge
module axi4_lite_sram_delay
   import axi4_lite_sram_pkg::*;
#(
   parameter int unsigned LATENCY = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic tick,
   output logic zero,
   output logic done
);

   logic [CNT_WIDTH-1:0] load_val;
   logic [CNT_WIDTH-1:0] target;
   logic [CNT_WIDTH-1:0] count;

`ifdef AXI4_LITE_SRAM_RAND_DELAY_EN
   logic [3:0] lfsr;

   assign load_val = CNT_WIDTH'(LATENCY) + CNT_WIDTH'(lfsr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr <= LFSR_SEED;
      end else if (start) begin
         lfsr <= lfsr4_next(lfsr);
      end
   end
`else
   assign load_val = CNT_WIDTH'(LATENCY);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         target <= '0;
         count  <= '0;
      end else if (start) begin
         target <= load_val;
         count  <= '0;
      end else if (tick) begin
         count <= count + CNT_WIDTH'(1);
      end
   end

   assign zero = (load_val == '0);
   assign done = ((count + CNT_WIDTH'(1)) == target);

endmodule

// File: rtl/axi4_lite_sram.sv
// axi4_lite_sram
// AXI4-Lite slave backed by a DEPTH x 32-bit word array at BASE_ADDR. Independent read and
// write FSMs, each with a programmable extra latency; out-of-range accesses answer SLVERR.
// Optional feature macro: AXI4_LITE_SRAM_RAND_DELAY_EN (random extra latency per transaction).
// Ports:
//   iClock, iReset              : clock, asynchronous active-high reset
//   pAXI4_ar_* / pAXI4_r_*      : read address / read data channels
//   pAXI4_aw_* / pAXI4_w_*      : write address / write data channels
//   pAXI4_b_*                   : write response channel
module axi4_lite_sram
   import axi4_lite_sram_pkg::*;
#(
   parameter int unsigned            DEPTH      = 1024,
   parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = 32'h8000_0000,
   parameter int unsigned            RD_LATENCY = 1,
   parameter int unsigned            WR_LATENCY = 1
) (
   input  logic                  iClock,
   input  logic                  iReset,
   input  logic                  pAXI4_ar_valid,
   input  logic [ADDR_WIDTH-1:0] pAXI4_ar_bits_addr,
   output logic                  pAXI4_ar_ready,
   output logic                  pAXI4_r_valid,
   output logic [DATA_WIDTH-1:0] pAXI4_r_bits_data,
   output logic [RESP_WIDTH-1:0] pAXI4_r_bits_resp,
   input  logic                  pAXI4_r_ready,
   input  logic                  pAXI4_aw_valid,
   input  logic [ADDR_WIDTH-1:0] pAXI4_aw_bits_addr,
   output logic                  pAXI4_aw_ready,
   input  logic                  pAXI4_w_valid,
   input  logic [DATA_WIDTH-1:0] pAXI4_w_bits_data,
   input  logic [MASK_WIDTH-1:0] pAXI4_w_bits_strb,
   output logic                  pAXI4_w_ready,
   output logic                  pAXI4_b_valid,
   output logic [RESP_WIDTH-1:0] pAXI4_b_bits_resp,
   input  logic                  pAXI4_b_ready
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_t;
   typedef enum logic [1:0] {WR_IDLE, WR_WAIT, WR_RESP} wr_state_t;

   function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
      logic [ADDR_WIDTH:0] off;
      off = {1'b0, addr} - {1'b0, BASE_ADDR};
      // off[ADDR_WIDTH] is the borrow: address below the base.
      return !off[ADDR_WIDTH] && (off[ADDR_WIDTH-1:0] < ADDR_WIDTH'(4 * DEPTH));
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
      return IDX_W'((addr - BASE_ADDR) >> 2);
   endfunction

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Holds the ready outputs low until the first edge after reset is released.
   logic ready_en;

   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) ready_en <= 1'b0;
      else        ready_en <= 1'b1;
   end

   // ---------------------------------------------------------------- read path
   rd_state_t             rd_state, rd_state_next;
   logic [ADDR_WIDTH-1:0] rd_addr, rd_addr_eff;
   logic [DATA_WIDTH-1:0] r_data;
   logic [RESP_WIDTH-1:0] r_resp;
   logic                  ar_hs, rd_start, rd_fetch, rd_zero, rd_done;

   assign pAXI4_ar_ready = ready_en && (rd_state == RD_IDLE);
   assign ar_hs          = pAXI4_ar_valid && pAXI4_ar_ready;
   // With zero latency the fetch happens on the handshake edge, before rd_addr is loaded.
   assign rd_addr_eff    = (rd_state == RD_IDLE) ? pAXI4_ar_bits_addr : rd_addr;

   always_comb begin
      rd_state_next = rd_state;
      rd_start      = 1'b0;
      rd_fetch      = 1'b0;
      case (rd_state)
         RD_IDLE: begin
            if (ar_hs) begin
               rd_start = 1'b1;
               if (rd_zero) begin
                  rd_state_next = RD_RESP;
                  rd_fetch      = 1'b1;
               end else begin
                  rd_state_next = RD_WAIT;
               end
            end
         end
         RD_WAIT: begin
            if (rd_done) begin
               rd_state_next = RD_RESP;
               rd_fetch      = 1'b1;
            end
         end
         RD_RESP: begin
            if (pAXI4_r_ready) rd_state_next = RD_IDLE;
         end
         default: rd_state_next = RD_IDLE;
      endcase
   end

   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         rd_state <= RD_IDLE;
         rd_addr  <= '0;
         r_data   <= '0;
         r_resp   <= RESP_OKEY;
      end else begin
         rd_state <= rd_state_next;
         if (ar_hs) rd_addr <= pAXI4_ar_bits_addr;
         // Sampled with non-blocking semantics, so a same-edge write commit is not seen.
         if (rd_fetch) begin
            if (in_range(rd_addr_eff)) begin
               r_data <= mem[word_idx(rd_addr_eff)];
               r_resp <= RESP_OKEY;
            end else begin
               r_data <= '0;
               r_resp <= RESP_SLVERR;
            end
         end
      end
   end

   assign pAXI4_r_valid     = (rd_state == RD_RESP);
   assign pAXI4_r_bits_data = r_data;
   assign pAXI4_r_bits_resp = r_resp;

   axi4_lite_sram_delay #(
      .LATENCY (RD_LATENCY)
   ) u_rd_delay (
      .clk   (iClock),
      .rst   (iReset),
      .start (rd_start),
      .tick  (rd_state == RD_WAIT),
      .zero  (rd_zero),
      .done  (rd_done)
   );

   // --------------------------------------------------------------- write path
   wr_state_t             wr_state, wr_state_next;
   logic                  aw_captured, w_captured;
   logic [ADDR_WIDTH-1:0] aw_addr, wr_addr_eff;
   logic [DATA_WIDTH-1:0] w_data, wr_data_eff;
   logic [MASK_WIDTH-1:0] w_strb, wr_strb_eff;
   logic [RESP_WIDTH-1:0] b_resp;
   logic                  aw_hs, w_hs, wr_start, wr_commit, wr_zero, wr_done, b_hs;

   assign pAXI4_aw_ready = ready_en && (wr_state == WR_IDLE) && !aw_captured;
   assign pAXI4_w_ready  = ready_en && (wr_state == WR_IDLE) && !w_captured;
   assign aw_hs          = pAXI4_aw_valid && pAXI4_aw_ready;
   assign w_hs           = pAXI4_w_valid && pAXI4_w_ready;
   assign b_hs           = (wr_state == WR_RESP) && pAXI4_b_ready;

   // The half that completes the pair may still be on the bus rather than in a register.
   assign wr_addr_eff = aw_captured ? aw_addr : pAXI4_aw_bits_addr;
   assign wr_data_eff = w_captured  ? w_data  : pAXI4_w_bits_data;
   assign wr_strb_eff = w_captured  ? w_strb  : pAXI4_w_bits_strb;

   always_comb begin
      wr_state_next = wr_state;
      wr_start      = 1'b0;
      wr_commit     = 1'b0;
      case (wr_state)
         WR_IDLE: begin
            if ((aw_captured || aw_hs) && (w_captured || w_hs)) begin
               wr_start = 1'b1;
               if (wr_zero) begin
                  wr_state_next = WR_RESP;
                  wr_commit     = 1'b1;
               end else begin
                  wr_state_next = WR_WAIT;
               end
            end
         end
         WR_WAIT: begin
            if (wr_done) begin
               wr_state_next = WR_RESP;
               wr_commit     = 1'b1;
            end
         end
         WR_RESP: begin
            if (pAXI4_b_ready) wr_state_next = WR_IDLE;
         end
         default: wr_state_next = WR_IDLE;
      endcase
   end

   always_ff @(posedge iClock or posedge iReset) begin
      if (iReset) begin
         wr_state    <= WR_IDLE;
         aw_captured <= 1'b0;
         w_captured  <= 1'b0;
         aw_addr     <= '0;
         w_data      <= '0;
         w_strb      <= '0;
         b_resp      <= RESP_OKEY;
      end else begin
         wr_state <= wr_state_next;
         if (b_hs) begin
            aw_captured <= 1'b0;
            w_captured  <= 1'b0;
         end else begin
            if (aw_hs) begin
               aw_captured <= 1'b1;
               aw_addr     <= pAXI4_aw_bits_addr;
            end
            if (w_hs) begin
               w_captured <= 1'b1;
               w_data     <= pAXI4_w_bits_data;
               w_strb     <= pAXI4_w_bits_strb;
            end
         end
         if (wr_commit) b_resp <= in_range(wr_addr_eff) ? RESP_OKEY : RESP_SLVERR;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge iClock) begin
      if (wr_commit && in_range(wr_addr_eff)) begin
         for (int i = 0; i < int'(MASK_WIDTH); i++) begin
            if (wr_strb_eff[i]) mem[word_idx(wr_addr_eff)][8*i +: 8] <= wr_data_eff[8*i +: 8];
         end
      end
   end

   assign pAXI4_b_valid     = (wr_state == WR_RESP);
   assign pAXI4_b_bits_resp = b_resp;

   axi4_lite_sram_delay #(
      .LATENCY (WR_LATENCY)
   ) u_wr_delay (
      .clk   (iClock),
      .rst   (iReset),
      .start (wr_start),
      .tick  (wr_state == WR_WAIT),
      .zero  (wr_zero),
      .done  (wr_done)
   );

endmodule

// File: tb/tb_axi4_lite_sram.sv
// tb_axi4_lite_sram
// Scoreboard bench for axi4_lite_sram: issuing tasks push expected responses from a word-array
// reference model; a negedge monitor pops and compares on every R/B handshake and checks
// latency, stability and ready behaviour. Honours AXI4_LITE_SRAM_RAND_DELAY_EN.
module tb_axi4_lite_sram;
   import axi4_lite_sram_pkg::*;

   localparam int unsigned DEPTH  = 1024;
   localparam logic [31:0] BASE   = 32'h8000_0000;
   localparam int          RD_LAT = 1;
   localparam int          WR_LAT = 1;

   logic        iClock = 1'b0;
   logic        iReset = 1'b1;
   logic        ar_valid, aw_valid, w_valid, r_ready, b_ready;
   logic [31:0] ar_addr, aw_addr, w_data;
   logic [3:0]  w_strb;
   logic        pAXI4_ar_ready, pAXI4_r_valid, pAXI4_aw_ready, pAXI4_w_ready, pAXI4_b_valid;
   logic [31:0] r_data;
   logic [1:0]  r_resp, b_resp;

   always #5 iClock = ~iClock;

   axi4_lite_sram #(
      .DEPTH      (DEPTH),
      .BASE_ADDR  (BASE),
      .RD_LATENCY (RD_LAT),
      .WR_LATENCY (WR_LAT)
   ) dut (
      .iClock             (iClock),
      .iReset             (iReset),
      .pAXI4_ar_valid     (ar_valid),
      .pAXI4_ar_bits_addr (ar_addr),
      .pAXI4_ar_ready     (pAXI4_ar_ready),
      .pAXI4_r_valid      (pAXI4_r_valid),
      .pAXI4_r_bits_data  (r_data),
      .pAXI4_r_bits_resp  (r_resp),
      .pAXI4_r_ready      (r_ready),
      .pAXI4_aw_valid     (aw_valid),
      .pAXI4_aw_bits_addr (aw_addr),
      .pAXI4_aw_ready     (pAXI4_aw_ready),
      .pAXI4_w_valid      (w_valid),
      .pAXI4_w_bits_data  (w_data),
      .pAXI4_w_bits_strb  (w_strb),
      .pAXI4_w_ready      (pAXI4_w_ready),
      .pAXI4_b_valid      (pAXI4_b_valid),
      .pAXI4_b_bits_resp  (b_resp),
      .pAXI4_b_ready      (b_ready)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge iClock) cyc <= cyc + 1;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } rexp_t;

   rexp_t       rq[$];
   logic [1:0]  bq[$];
   logic [31:0] model [0:DEPTH-1];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic bit m_in(input logic [31:0] a);
      return (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
   endfunction

   function automatic int m_idx(input logic [31:0] a);
      return int'((a - BASE) / 4);
   endfunction

   // Extra latency drawn from the per-channel LFSR when the random-delay build is used.
   function automatic int extra(input logic [3:0] l);
`ifdef AXI4_LITE_SRAM_RAND_DELAY_EN
      return int'(l);
`else
      return 0 * int'(l);
`endif
   endfunction

   function automatic logic [3:0] lfsr_step(input logic [3:0] l);
      return {l[2:0], l[3] ^ l[2]};
   endfunction

   function automatic logic sig(input int s);
      case (s)
         0:       return pAXI4_ar_ready;
         1:       return pAXI4_aw_ready;
         2:       return pAXI4_w_ready;
         3:       return pAXI4_r_valid;
         4:       return pAXI4_b_valid;
         default: return 1'b0;
      endcase
   endfunction

   // Waits (bounded) until the selected DUT signal is high at a falling edge.
   task automatic wait_hi(input int s, input string name);
      int t;
      t = 0;
      @(negedge iClock);
      while (!sig(s) && t < 200) begin
         @(negedge iClock);
         t++;
      end
      if (!sig(s)) begin
         checks++;
         errors++;
         $display("FAIL timeout %s: got 0 expected 1 within 200 cycles", name);
      end
   endtask

   task automatic rd(input logic [31:0] a, input int hold);
      rexp_t e;
      if (m_in(a)) begin
         e.data = model[m_idx(a)];
         e.resp = 2'b00;
      end else begin
         e.data = 32'h0;
         e.resp = 2'b10;
      end
      rq.push_back(e);
      @(posedge iClock); #1;
      ar_valid = 1'b1;
      ar_addr  = a;
      wait_hi(0, "ar_ready");
      @(posedge iClock); #1;
      ar_valid = 1'b0;
      if (hold > 0) begin
         repeat (hold) @(posedge iClock);
         #1;
      end
      r_ready = 1'b1;
      wait_hi(3, "r_valid");
      @(posedge iClock); #1;
      r_ready = 1'b0;
   endtask

   // lead > 0: W goes out lead cycles before AW; lead < 0: AW first.
   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input int lead, input int hold);
      bq.push_back(m_in(a) ? 2'b00 : 2'b10);
      if (m_in(a)) begin
         for (int i = 0; i < 4; i++) if (s[i]) model[m_idx(a)][8*i +: 8] = d[8*i +: 8];
      end
      @(posedge iClock); #1;
      fork
         begin
            if (lead > 0) begin
               repeat (lead) @(posedge iClock);
               #1;
            end
            aw_valid = 1'b1;
            aw_addr  = a;
            wait_hi(1, "aw_ready");
            @(posedge iClock); #1;
            aw_valid = 1'b0;
         end
         begin
            if (lead < 0) begin
               repeat (-lead) @(posedge iClock);
               #1;
            end
            w_valid = 1'b1;
            w_data  = d;
            w_strb  = s;
            wait_hi(2, "w_ready");
            @(posedge iClock); #1;
            w_valid = 1'b0;
         end
      join
      if (hold > 0) begin
         repeat (hold) @(posedge iClock);
         #1;
      end
      b_ready = 1'b1;
      wait_hi(4, "b_valid");
      @(posedge iClock); #1;
      b_ready = 1'b0;
   endtask

   // ------------------------------------------------------------------ monitor
   int          ar_c, aw_c, w_c, rd_exp_lat, wr_exp_lat, wr_last;
   bit          r_seen, b_seen, r_hs_prev;
   logic [31:0] prev_rd;
   logic [1:0]  prev_rresp;
   logic [3:0]  rd_lfsr, wr_lfsr;

   always @(negedge iClock) begin
      if (iReset) begin
         ar_c = -1; aw_c = -1; w_c = -1;
         r_seen = 0; b_seen = 0; r_hs_prev = 0;
         rd_lfsr = 4'b1001; wr_lfsr = 4'b1001;
      end else begin
         if (r_hs_prev) chk("ar_ready after r handshake", 32'(pAXI4_ar_ready), 32'd1);
         r_hs_prev = 0;
         if (ar_valid && pAXI4_ar_ready) begin
            ar_c       = cyc;
            rd_exp_lat = 1 + RD_LAT + extra(rd_lfsr);
            rd_lfsr    = lfsr_step(rd_lfsr);
         end
         if (aw_valid && pAXI4_aw_ready) aw_c = cyc;
         if (w_valid && pAXI4_w_ready) w_c = cyc;
         if (aw_c >= 0 && w_c >= 0) begin
            wr_last    = (aw_c > w_c) ? aw_c : w_c;
            wr_exp_lat = 1 + WR_LAT + extra(wr_lfsr);
            wr_lfsr    = lfsr_step(wr_lfsr);
            aw_c = -1;
            w_c  = -1;
         end
         if (pAXI4_r_valid) begin
            chk("ar_ready low while r_valid", 32'(pAXI4_ar_ready), 32'd0);
            if (!r_seen) begin
               r_seen = 1;
               chk("read latency", 32'(cyc - ar_c), 32'(rd_exp_lat));
            end else begin
               chk("r data stable", r_data, prev_rd);
               chk("r resp stable", 32'(r_resp), 32'(prev_rresp));
            end
            prev_rd    = r_data;
            prev_rresp = r_resp;
            if (r_ready) begin
               if (rq.size() == 0) begin
                  chk("unexpected r response", 32'd1, 32'd0);
               end else begin
                  rexp_t e;
                  e = rq.pop_front();
                  chk("r data", r_data, e.data);
                  chk("r resp", 32'(r_resp), 32'(e.resp));
               end
               r_seen    = 0;
               r_hs_prev = 1;
            end
         end
         if (pAXI4_b_valid) begin
            chk("aw_ready low while b_valid", 32'(pAXI4_aw_ready), 32'd0);
            chk("w_ready low while b_valid", 32'(pAXI4_w_ready), 32'd0);
            if (!b_seen) begin
               b_seen = 1;
               chk("write latency", 32'(cyc - wr_last), 32'(wr_exp_lat));
            end
            if (b_ready) begin
               if (bq.size() == 0) chk("unexpected b response", 32'd1, 32'd0);
               else chk("b resp", 32'(b_resp), 32'(bq.pop_front()));
               b_seen = 0;
            end
         end
      end
   end

   // ------------------------------------------------------------------ stimulus
   function automatic logic [31:0] pick_addr();
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) return BASE - 32'(4 * $urandom_range(1, 4));
      if (r == 1) return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
      return BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
   endfunction

   logic [31:0] a1, a2;
   int          op;

   initial begin
      ar_valid = 0; aw_valid = 0; w_valid = 0; r_ready = 0; b_ready = 0;
      ar_addr = '0; aw_addr = '0; w_data = '0; w_strb = '0;
      #1;
      chk("reset ar_ready", 32'(pAXI4_ar_ready), 32'd0);
      chk("reset aw_ready", 32'(pAXI4_aw_ready), 32'd0);
      chk("reset w_ready", 32'(pAXI4_w_ready), 32'd0);
      chk("reset r_valid", 32'(pAXI4_r_valid), 32'd0);
      chk("reset b_valid", 32'(pAXI4_b_valid), 32'd0);
      chk("reset r_data", r_data, 32'd0);
      chk("reset r_resp", 32'(r_resp), 32'd0);
      chk("reset b_resp", 32'(b_resp), 32'd0);
      repeat (2) @(posedge iClock);
      @(negedge iClock); #2;
      iReset = 1'b0;
      #1;
      chk("ar_ready before first edge", 32'(pAXI4_ar_ready), 32'd0);
      @(posedge iClock); #1;
      chk("ar_ready after first edge", 32'(pAXI4_ar_ready), 32'd1);
      chk("aw_ready after first edge", 32'(pAXI4_aw_ready), 32'd1);
      chk("w_ready after first edge", 32'(pAXI4_w_ready), 32'd1);

      for (int i = 0; i < 16; i++) wr(BASE + 32'(4 * i), $urandom, 4'hF, 0, 0);

      wr(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0);
      rd(32'h8000_0010, 0);
      wr(BASE + 32'h20, 32'hFFFF_FFFF, 4'hF, 0, 0);
      wr(BASE + 32'h20, 32'h1122_3344, 4'b0101, 3, 1);
      rd(BASE + 32'h20, 0);
      wr(BASE + 32'h24, $urandom, 4'b0000, -2, 0);
      rd(BASE + 32'h24, 1);
      rd(BASE + 32'h11, 0);
      rd(32'h7FFF_FFFC, 0);
      wr(BASE + 32'(4 * DEPTH), 32'h1234_5678, 4'hF, 0, 0);
      rd(BASE, 0);
      rd(BASE + 32'(4 * DEPTH), 0);
      wr(BASE + 32'(4 * DEPTH) - 32'd4, 32'hA5A5_0F0F, 4'hF, 1, 0);
      rd(BASE + 32'(4 * DEPTH) - 32'd4, 0);
      rd(BASE + 32'h10, 12);

      // Reset while the write sits in its wait state: no response, no commit.
      @(posedge iClock); #1;
      aw_valid = 1'b1; aw_addr = BASE + 32'h30;
      w_valid = 1'b1; w_data = 32'hCAFE_F00D; w_strb = 4'hF;
      wait_hi(1, "aw_ready before reset");
      @(posedge iClock); #1;
      aw_valid = 1'b0; w_valid = 1'b0;
      iReset = 1'b1;
      #1;
      chk("b_valid on reset", 32'(pAXI4_b_valid), 32'd0);
      chk("aw_ready on reset", 32'(pAXI4_aw_ready), 32'd0);
      repeat (2) @(posedge iClock);
      #1;
      chk("b_valid held in reset", 32'(pAXI4_b_valid), 32'd0);
      @(negedge iClock); #2;
      iReset = 1'b0;
      #1;
      chk("aw_ready before first edge", 32'(pAXI4_aw_ready), 32'd0);
      @(posedge iClock); #1;
      chk("aw_ready after reset edge", 32'(pAXI4_aw_ready), 32'd1);
      rd(BASE + 32'h30, 0);
      wr(BASE + 32'h30, 32'h0BAD_CAFE, 4'hF, -1, 2);
      rd(BASE + 32'h30, 0);

      for (int k = 0; k < 60; k++) begin
         op = int'($urandom_range(0, 2));
         a1 = pick_addr();
         if (op == 0) begin
            rd(a1, int'($urandom_range(0, 3)));
         end else if (op == 1) begin
            wr(a1, $urandom, 4'($urandom), int'($urandom_range(0, 6)) - 3,
               int'($urandom_range(0, 3)));
         end else begin
            a1 = BASE + 32'(4 * $urandom_range(0, 7));
            a2 = BASE + 32'(4 * $urandom_range(8, 15));
            fork
               rd(a1, int'($urandom_range(0, 2)));
               wr(a2, $urandom, 4'($urandom), int'($urandom_range(0, 4)) - 2,
                  int'($urandom_range(0, 2)));
            join
         end
      end

      repeat (5) @(posedge iClock);
      chk("r queue drained", 32'(rq.size()), 32'd0);
      chk("b queue drained", 32'(bq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, expected finish before 50000 cycles");
      $fatal(1, "watchdog expired");
   end

endmodule
